// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DEFAULT_DATA_BITS  = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for an asynchronous input; flops reset to 1 (idle line level).
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_chain;

  // NOTE: resetting to 1 keeps a reset from ever looking like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain <= '1;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver driven by an OVERSAMPLE x baud tick; samples each bit at its centre.
// Define UART_RX_PARITY_EN to add a parity bit before the stop bit and the parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DEFAULT_DATA_BITS,
  parameter int OVERSAMPLE  = DEFAULT_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD  = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] MID_START = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] MID_BIT   = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

  uart_state_e          r_state;
  uart_state_e          w_state_next;
  logic [CNT_W-1:0]     r_tick_cnt;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 w_rx_s;
  logic                 w_start_mid;
  logic                 w_bit_mid;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_err;
`endif

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_async(rx),
    .o_sync (w_rx_s)
  );

  assign w_start_mid = sample_tick && (r_tick_cnt == MID_START);
  assign w_bit_mid   = sample_tick && (r_tick_cnt == MID_BIT);
  assign busy        = (r_state != ST_IDLE);

  // NOTE: default first so every path assigns w_state_next and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (!w_rx_s) w_state_next = ST_START;
      ST_START:  if (w_start_mid) w_state_next = w_rx_s ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (w_bit_mid && (r_bit_idx == LAST_IDX)) begin
`ifdef UART_RX_PARITY_EN
          w_state_next = ST_PARITY;
`else
          w_state_next = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (w_bit_mid) w_state_next = ST_STOP;
`endif
      ST_STOP:   if (w_bit_mid) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking throughout, so every read below sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_tick_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_err  <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_next;
      rx_valid <= 1'b0;

      // Counter restarts on any state change and at each mid-bit sample.
      if ((w_state_next != r_state) || w_bit_mid) begin
        r_tick_cnt <= '0;
      end else if (sample_tick && (r_state != ST_IDLE)) begin
        r_tick_cnt <= r_tick_cnt + CNT_W'(1);
      end

      if ((r_state == ST_START) && w_start_mid) begin
        r_bit_idx <= '0;
      end

      if ((r_state == ST_DATA) && w_bit_mid) begin
        r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
        r_bit_idx <= r_bit_idx + IDX_W'(1);
      end

`ifdef UART_RX_PARITY_EN
      if ((r_state == ST_PARITY) && w_bit_mid) begin
        r_par_err <= (^r_shift) ^ w_rx_s ^ PARITY_ODD;
      end
`endif

      if ((r_state == ST_STOP) && w_bit_mid) begin
        rx_data    <= r_shift;
        frame_err  <= ~w_rx_s;
        rx_valid   <= 1'b1;
`ifdef UART_RX_PARITY_EN
        parity_err <= r_par_err;
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised self-checking bench for uart_rx: frames are built from bytes and compared
// against an expected-frame queue; build with UART_RX_PARITY_EN to cover the parity bit.
module tb_uart_rx;

  localparam int OS = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } frame_t;

  logic       clk;
  logic       rst;
  logic       sample_tick;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int     errors = 0;
  int     checks = 0;
  int     gap_lo = 2;
  int     gap_hi = 2;
  frame_t exp_q[$];
  frame_t obs_q[$];

  uart_rx #(
    .DATA_BITS  (8),
    .OVERSAMPLE (OS),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_tick(sample_tick),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Record every strobe seen by the consumer.
  always @(negedge clk) begin
    if (rx_valid) begin
      frame_t o;
      o.data = rx_data;
      o.ferr = frame_err;
`ifdef UART_RX_PARITY_EN
      o.perr = parity_err;
`else
      o.perr = 1'b0;
`endif
      obs_q.push_back(o);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic one_tick();
    @(negedge clk) sample_tick = 1'b1;
    @(negedge clk) sample_tick = 1'b0;
    repeat ($urandom_range(gap_hi, gap_lo)) @(negedge clk);
  endtask

  task automatic bit_ticks(input logic level, input int n);
    rx = level;
    repeat (n) one_tick();
  endtask

  task automatic idle_ticks(input int n);
    bit_ticks(1'b1, n);
  endtask

  // Drives one frame; rst_bit >= 0 pulses reset in the middle of that data bit.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_bit,
                            input int rst_bit);
    frame_t e;
    bit_ticks(1'b0, OS);
    for (int i = 0; i < 8; i++) begin
      if (i == rst_bit) begin
        rx = d[i];
        repeat (5) one_tick();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        repeat (OS - 5) one_tick();
      end else begin
        bit_ticks(d[i], OS);
      end
    end
`ifdef UART_RX_PARITY_EN
    bit_ticks(par_bit, OS);
`endif
    if (stop_ok) begin
      bit_ticks(1'b1, OS);
    end else begin
      bit_ticks(1'b0, 12);
      bit_ticks(1'b1, 4);
    end
    if (rst_bit < 0) begin
      e.data = d;
      e.ferr = !stop_ok;
`ifdef UART_RX_PARITY_EN
      e.perr = ((($countones(d) + int'(par_bit)) % 2) != 0);
`else
      e.perr = par_bit & 1'b0;
`endif
      exp_q.push_back(e);
    end
  endtask

  task automatic compare_frames(input string tag);
    frame_t o;
    frame_t e;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_data"}, o.data, e.data);
      check({tag, "_ferr"}, o.ferr, e.ferr);
`ifdef UART_RX_PARITY_EN
      check({tag, "_perr"}, o.perr, e.perr);
`endif
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    bit         stop_ok;
    bit         pb;

    rst         = 1'b1;
    rx          = 1'b1;
    sample_tick = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_data", rx_data, 8'h00);
    check("reset_valid", rx_valid, 1'b0);
    check("reset_ferr", frame_err, 1'b0);
    check("reset_busy", busy, 1'b0);

    // Clean frame, tick every 4 clocks.
    send_frame(8'hA5, 1'b1, 1'b0, -1);
    idle_ticks(4);
    compare_frames("a5");
    check("a5_busy", busy, 1'b0);

    // Short low pulse is rejected as a glitch.
    bit_ticks(1'b0, 4);
    idle_ticks(24);
    compare_frames("glitch");
    check("glitch_busy", busy, 1'b0);
    check("glitch_hold", rx_data, 8'hA5);

    // Bad stop bit, then a good frame.
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    idle_ticks(20);
    send_frame(8'h55, 1'b1, 1'b0, -1);
    idle_ticks(4);
    compare_frames("ferr");

    // Reset during bit 3 aborts the frame and clears the outputs.
    send_frame(8'hFF, 1'b1, 1'b0, 3);
    idle_ticks(8);
    compare_frames("abort");
    check("abort_data", rx_data, 8'h00);
    check("abort_ferr", frame_err, 1'b0);
    check("abort_busy", busy, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0, -1);
    idle_ticks(4);
    compare_frames("after_abort");

    // Back-to-back frames, no idle gap.
    send_frame(8'h00, 1'b1, 1'b0, -1);
    send_frame(8'hFF, 1'b1, 1'b0, -1);
    idle_ticks(4);
    compare_frames("b2b");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, -1);
    idle_ticks(4);
    compare_frames("par_good");
    send_frame(8'h07, 1'b1, 1'b0, -1);
    idle_ticks(4);
    compare_frames("par_bad");
`endif

    // Random bytes, stop bits and irregular tick spacing.
    gap_lo = 0;
    gap_hi = 4;
    for (int n = 0; n < 16; n++) begin
      d       = 8'($urandom);
      stop_ok = ($urandom_range(3, 0) != 0);
      pb      = 1'($urandom);
      send_frame(d, stop_ok, pb, -1);
      idle_ticks(stop_ok ? int'($urandom_range(3, 0)) : 16 + int'($urandom_range(4, 0)));
      compare_frames("rand");
    end
    idle_ticks(8);
    check("final_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
